// File: rtl/fft_result_unloader_pkg.sv
// Shared definitions for the FFT result unloader: controller states and
// default transform / search-window geometry.
package fft_result_unloader_pkg;

   localparam int FFT_NFFT_LOG2 = 13;
   localparam int FFT_XK_W      = 38;
   localparam int FFT_MAG_W     = FFT_XK_W + 1;
   localparam int FFT_BIN_LO    = 1;
   localparam int FFT_BIN_HI    = 4095;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UNLOAD = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_REPORT = 3'd4
   } state_t;

endpackage

// File: rtl/fft_result_unloader_mag.sv
// Two-stage alpha-max-beta-min magnitude pipeline: stage 1 registers |re|, |im|
// and sideband; stage 2 (combinational here) forms max + min/2.
module fft_mag_approx
   import fft_result_unloader_pkg::*;
#(
   parameter int XK_W   = FFT_XK_W,
   parameter int MAG_W  = FFT_MAG_W,
   parameter int IDX_W  = FFT_NFFT_LOG2,
   parameter int BIN_LO = FFT_BIN_LO,
   parameter int BIN_HI = FFT_BIN_HI
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [IDX_W-1:0]        in_index,
   input  logic signed [XK_W-1:0]  in_re,
   input  logic signed [XK_W-1:0]  in_im,
   output logic                    out_valid,
   output logic                    out_in_window,
   output logic [IDX_W-1:0]        out_index,
   output logic [MAG_W-1:0]        out_mag
);

   localparam logic [IDX_W-1:0] LO_IDX = IDX_W'(BIN_LO);
   localparam logic [IDX_W-1:0] HI_IDX = IDX_W'(BIN_HI);

   // The most negative input maps to 2^(XK_W-1), which still fits unsigned.
   function automatic logic [XK_W-1:0] abs_val(input logic signed [XK_W-1:0] v);
      logic [XK_W-1:0] r;
      if (v[XK_W-1]) begin
         r = ~v + {{(XK_W-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   logic               valid_r;
   logic               win_r;
   logic [IDX_W-1:0]   idx_r;
   logic [XK_W-1:0]    re_abs_r;
   logic [XK_W-1:0]    im_abs_r;
   logic [XK_W-1:0]    max_s;
   logic [XK_W-1:0]    min_s;

   // Stage 1: absolute values, index and window flag captured on each valid bin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r  <= 1'b0;
         win_r    <= 1'b0;
         idx_r    <= '0;
         re_abs_r <= '0;
         im_abs_r <= '0;
      end else begin
         valid_r <= in_valid;
         if (in_valid) begin
            win_r    <= (in_index >= LO_IDX) && (in_index <= HI_IDX);
            idx_r    <= in_index;
            re_abs_r <= abs_val(in_re);
            im_abs_r <= abs_val(in_im);
         end else begin
            win_r    <= win_r;
            idx_r    <= idx_r;
            re_abs_r <= re_abs_r;
            im_abs_r <= im_abs_r;
         end
      end
   end

   // Stage 2: order the two components for the max + min/2 estimate.
   always_comb begin
      max_s = re_abs_r;
      min_s = im_abs_r;
      if (im_abs_r > re_abs_r) begin
         max_s = im_abs_r;
         min_s = re_abs_r;
      end else begin
         max_s = re_abs_r;
         min_s = im_abs_r;
      end
   end

   assign out_valid     = valid_r;
   assign out_in_window = win_r;
   assign out_index     = idx_r;
   assign out_mag       = MAG_W'(max_s) + MAG_W'(min_s >> 1);

endmodule

// File: rtl/fft_result_unloader.sv
// Unloads one FFT frame per done pulse, tracks the peak magnitude bin inside
// the search window and reports it through a valid/ack handshake.
module fft_result_unloader
   import fft_result_unloader_pkg::*;
#(
   parameter int NFFT_LOG2 = FFT_NFFT_LOG2,
   parameter int XK_W      = FFT_XK_W,
   parameter int MAG_W     = FFT_MAG_W,
   parameter int BIN_LO    = FFT_BIN_LO,
   parameter int BIN_HI    = FFT_BIN_HI
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        done,
   input  logic                        dv,
   input  logic [NFFT_LOG2-1:0]        xk_index,
   input  logic signed [XK_W-1:0]      xk_re,
   input  logic signed [XK_W-1:0]      xk_im,
   output logic                        unload,
   output logic                        peak_valid,
   output logic [NFFT_LOG2-1:0]        peak_index,
   output logic [MAG_W-1:0]            peak_mag,
   input  logic                        peak_ack,
   output logic [15:0]                 frame_count,
   output logic                        overrun
);

   localparam logic [NFFT_LOG2-1:0] LAST_IDX   = {NFFT_LOG2{1'b1}};
   localparam logic [NFFT_LOG2-1:0] BIN_LO_IDX = NFFT_LOG2'(BIN_LO);

   state_t                 state_r, state_s;
   logic                   drain_cnt_r;
   logic                   unload_r, peak_valid_r, overrun_r;
   logic [NFFT_LOG2-1:0]   peak_index_r, best_idx_r, mag_index_s;
   logic [MAG_W-1:0]       peak_mag_r, best_mag_r, mag_s;
   logic [15:0]            frame_count_r;
   logic                   feed_s, last_bin_s, ack_s, mag_valid_s, mag_win_s;

   assign feed_s     = (state_r == ST_STREAM) && dv;
   assign last_bin_s = feed_s && (xk_index == LAST_IDX);
   assign ack_s      = (state_r == ST_REPORT) && peak_valid_r && peak_ack;

   fft_mag_approx #(
      .XK_W   (XK_W),
      .MAG_W  (MAG_W),
      .IDX_W  (NFFT_LOG2),
      .BIN_LO (BIN_LO),
      .BIN_HI (BIN_HI)
   ) u_mag (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (feed_s),
      .in_index      (xk_index),
      .in_re         (xk_re),
      .in_im         (xk_im),
      .out_valid     (mag_valid_s),
      .out_in_window (mag_win_s),
      .out_index     (mag_index_s),
      .out_mag       (mag_s)
   );

   // Next-state logic for the unload controller.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:   if (enable && done) state_s = ST_UNLOAD; else state_s = ST_IDLE;
         ST_UNLOAD: state_s = ST_STREAM;
         ST_STREAM: if (last_bin_s) state_s = ST_DRAIN; else state_s = ST_STREAM;
         ST_DRAIN:  if (drain_cnt_r) state_s = ST_REPORT; else state_s = ST_DRAIN;
         ST_REPORT: if (ack_s) state_s = ST_IDLE; else state_s = ST_REPORT;
         default:   state_s = ST_IDLE;
      endcase
   end

   // State register plus the two-cycle drain counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         drain_cnt_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         drain_cnt_r <= (state_r == ST_DRAIN) ? ~drain_cnt_r : 1'b0;
      end
   end

   // Unload pulse and sticky overrun; done outside IDLE is never serviced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unload_r  <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         unload_r  <= (state_r == ST_IDLE) && enable && done;
         overrun_r <= overrun_r | (done && (state_r != ST_IDLE));
      end
   end

   // Peak tracker: strict compare so ties keep the earlier (lower) bin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_mag_r <= '0;
         best_idx_r <= BIN_LO_IDX;
      end else if (state_r == ST_UNLOAD) begin
         best_mag_r <= '0;
         best_idx_r <= BIN_LO_IDX;
      end else if (mag_valid_s && mag_win_s && (mag_s > best_mag_r)) begin
         best_mag_r <= mag_s;
         best_idx_r <= mag_index_s;
      end else begin
         best_mag_r <= best_mag_r;
         best_idx_r <= best_idx_r;
      end
   end

   // Result latch and handshake; the tracker has settled by the end of drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_valid_r  <= 1'b0;
         peak_index_r  <= '0;
         peak_mag_r    <= '0;
         frame_count_r <= 16'd0;
      end else if ((state_r == ST_DRAIN) && drain_cnt_r) begin
         peak_valid_r  <= 1'b1;
         peak_index_r  <= best_idx_r;
         peak_mag_r    <= best_mag_r;
         frame_count_r <= frame_count_r + 16'd1;
      end else if (ack_s) begin
         peak_valid_r  <= 1'b0;
      end else begin
         peak_valid_r  <= peak_valid_r;
      end
   end

   assign unload      = unload_r;
   assign peak_valid  = peak_valid_r;
   assign peak_index  = peak_index_r;
   assign peak_mag    = peak_mag_r;
   assign frame_count = frame_count_r;
   assign overrun     = overrun_r;

endmodule
